// File: rtl/pwm_fade_sequencer_pkg.sv
// Shared definitions for the PWM fade sequencer and its period timer.
// Contents:
//   DATA_W        duty-cycle width (matches the PWM peripheral's pwm_duty_cycle)
//   CLK_DIV_DEF   default clocks per PWM counter step
//   PWM_STEPS_DEF default PWM counter steps per period
//   state_t       sequencer state encoding
//   at_least_one  maps a zero configuration value to 1
package pwm_fade_sequencer_pkg;

  localparam int DATA_W        = 8;
  localparam int CLK_DIV_DEF   = 13;
  localparam int PWM_STEPS_DEF = 256;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } state_t;

  function automatic logic [DATA_W-1:0] at_least_one(input logic [DATA_W-1:0] v);
    return (v == '0) ? DATA_W'(1) : v;
  endfunction

endpackage

// File: rtl/pwm_fade_sequencer_period_timer.sv
// pwm_period_timer: free-running replica of the PWM peripheral's period
// counter. Flags the last clock of every PWM period so duty updates land
// exactly on a period boundary.
// Ports:
//   clk          clock
//   rst_n        synchronous active-low reset (counters to 0)
//   period_tick  high for one clock on the last clock of each period
module pwm_period_timer
  import pwm_fade_sequencer_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int PWM_STEPS = PWM_STEPS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic period_tick
);

  localparam int DIV_W  = (CLK_DIV > 1)   ? $clog2(CLK_DIV)   : 1;
  localparam int STEP_W = (PWM_STEPS > 1) ? $clog2(PWM_STEPS) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(PWM_STEPS - 1);

  logic [DIV_W-1:0]  div_cnt;
  logic [STEP_W-1:0] step_cnt;
  logic              div_wrap;

  assign div_wrap = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      step_cnt <= '0;
    end else if (div_wrap) begin
      div_cnt  <= '0;
      step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

  assign period_tick = div_wrap && (step_cnt == STEP_LAST);

endmodule

// File: rtl/pwm_fade_sequencer.sv
// pwm_fade_sequencer: ramps the PWM duty cycle toward a programmed target,
// one clamped step every cfg_interval PWM periods, either once or as a
// floor<->target triangle. Duty only changes on a period boundary.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   cfg_target     ramp end value (loop upper bound)
//   cfg_floor      loop lower bound
//   cfg_step       duty increment per update (0 -> 1)
//   cfg_interval   PWM periods per update (0 -> 1)
//   cfg_loop       0 one-shot, 1 triangle loop
//   start          pulse: latch cfg_* and begin (ignored while busy)
//   abort          pulse: return to idle, holding the duty (beats start)
//   duty_cycle     to the PWM peripheral
//   busy           ramp or loop in progress
//   done           one-clock pulse when a one-shot ramp finishes
//   period_tick    one-clock pulse on the last clock of each PWM period
module pwm_fade_sequencer
  import pwm_fade_sequencer_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int PWM_STEPS = PWM_STEPS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] cfg_target,
  input  logic [DATA_W-1:0] cfg_floor,
  input  logic [DATA_W-1:0] cfg_step,
  input  logic [DATA_W-1:0] cfg_interval,
  input  logic              cfg_loop,
  input  logic              start,
  input  logic              abort,
  output logic [DATA_W-1:0] duty_cycle,
  output logic              busy,
  output logic              done,
  output logic              period_tick
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] duty_d;
  logic [DATA_W-1:0] goal_q, goal_d;
  logic [DATA_W-1:0] int_cnt_q, int_cnt_d;
  logic [DATA_W-1:0] next_duty;
  logic              busy_d, done_d;

  logic [DATA_W-1:0] sh_target, sh_floor, sh_step, sh_interval;
  logic              sh_loop;
  logic              loop_eff, start_loop_eff;

  function automatic logic [DATA_W-1:0] sat_up(input logic [DATA_W-1:0] cur,
                                               input logic [DATA_W-1:0] stp,
                                               input logic [DATA_W-1:0] lim);
    logic [DATA_W:0] sum;
    sum = {1'b0, cur} + {1'b0, stp};
    return (sum >= {1'b0, lim}) ? lim : sum[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] sat_down(input logic [DATA_W-1:0] cur,
                                                 input logic [DATA_W-1:0] stp,
                                                 input logic [DATA_W-1:0] lim);
    logic signed [DATA_W:0] diff;
    diff = $signed({1'b0, cur}) - $signed({1'b0, stp});
    return (diff <= $signed({1'b0, lim})) ? lim : diff[DATA_W-1:0];
  endfunction

  pwm_period_timer #(
    .CLK_DIV   (CLK_DIV),
    .PWM_STEPS (PWM_STEPS)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .period_tick (period_tick)
  );

  // A loop whose floor is not below its target degenerates to a one-shot.
  assign loop_eff       = sh_loop  && (sh_floor  < sh_target);
  assign start_loop_eff = cfg_loop && (cfg_floor < cfg_target);

  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && start && !abort) begin
      sh_target   <= cfg_target;
      sh_floor    <= cfg_floor;
      sh_step     <= at_least_one(cfg_step);
      sh_interval <= at_least_one(cfg_interval);
      sh_loop     <= cfg_loop;
    end
  end

  always_comb begin
    state_d   = state_q;
    duty_d    = duty_cycle;
    goal_d    = goal_q;
    int_cnt_d = int_cnt_q;
    done_d    = 1'b0;
    next_duty = duty_cycle;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            int_cnt_d = at_least_one(cfg_interval);
            goal_d    = cfg_target;
            if (cfg_target > duty_cycle) begin
              state_d = RAMP_UP;
            end else if ((cfg_target < duty_cycle) || start_loop_eff) begin
              state_d = RAMP_DOWN;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        RAMP_UP, RAMP_DOWN: begin
          if (period_tick) begin
            if (int_cnt_q > DATA_W'(1)) begin
              int_cnt_d = int_cnt_q - 1'b1;
            end else begin
              int_cnt_d = sh_interval;
              next_duty = (state_q == RAMP_UP) ? sat_up(duty_cycle, sh_step, goal_q)
                                               : sat_down(duty_cycle, sh_step, goal_q);
              duty_d    = next_duty;
              if (next_duty == goal_q) begin
                if (loop_eff) begin
                  // Swap the goal; the direction always points at the new goal.
                  if (goal_q == sh_target) begin
                    goal_d  = sh_floor;
                    state_d = RAMP_DOWN;
                  end else begin
                    goal_d  = sh_target;
                    state_d = RAMP_UP;
                  end
                end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                end
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      duty_cycle <= '0;
      int_cnt_q  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_cycle <= duty_d;
      int_cnt_q  <= int_cnt_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    goal_q <= goal_d;
  end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Bench for pwm_fade_sequencer. u_ref runs the default period (3328 clk)
// for the timing checks; u_dut runs a short period so ramps finish quickly.
// A behavioural model predicts duty/busy/done/tick on every clock.
module tb_pwm_fade_sequencer;

  localparam int FP = 3 * 8;
  localparam int RP = 13 * 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cfg_target = 8'h00, cfg_floor = 8'h00, cfg_step = 8'h00, cfg_interval = 8'h00;
  logic       cfg_loop = 1'b0, start = 1'b0, abort = 1'b0;

  logic [7:0] duty_cycle, ref_duty;
  logic       busy, done, period_tick;
  logic       ref_busy, ref_done, ref_tick;

  pwm_fade_sequencer #(.CLK_DIV(3), .PWM_STEPS(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_target(cfg_target), .cfg_floor(cfg_floor),
    .cfg_step(cfg_step), .cfg_interval(cfg_interval), .cfg_loop(cfg_loop),
    .start(start), .abort(abort), .duty_cycle(duty_cycle), .busy(busy),
    .done(done), .period_tick(period_tick)
  );

  pwm_fade_sequencer u_ref (
    .clk(clk), .rst_n(rst_n), .cfg_target(cfg_target), .cfg_floor(cfg_floor),
    .cfg_step(cfg_step), .cfg_interval(cfg_interval), .cfg_loop(cfg_loop),
    .start(start), .abort(abort), .duty_cycle(ref_duty), .busy(ref_busy),
    .done(ref_done), .period_tick(ref_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ecnt     = 0;
  int ref_first  = -1;
  int ref_second = -1;

  int m_active, m_up, m_goal, m_duty, m_cnt, m_n, m_step, m_floor, m_target, m_loop_eff, m_done;

  typedef struct packed {
    logic [7:0]      tgt;
    logic [7:0]      flr;
    logic [7:0]      stp;
    logic [7:0]      ivl;
    logic            lp;
    int              nt;
    logic [5:0][7:0] ex;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(input logic [7:0] tgt, input logic [7:0] flr,
                              input logic [7:0] stp, input logic [7:0] ivl,
                              input logic lp, input int nt, input logic [47:0] ex);
    vec_t v;
    v.tgt = tgt; v.flr = flr; v.stp = stp; v.ivl = ivl; v.lp = lp; v.nt = nt; v.ex = ex;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, ecnt);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_up = 0; m_goal = 0; m_duty = 0; m_cnt = 0; m_n = 1;
    m_step = 1; m_floor = 0; m_target = 0; m_loop_eff = 0; m_done = 0;
  endtask

  task automatic model_edge(input bit st, input bit ab, input bit tk);
    int nd;
    m_done = 0;
    if (ab) begin
      m_active = 0;
    end else if (m_active == 0) begin
      if (st) begin
        m_target   = cfg_target;
        m_floor    = cfg_floor;
        m_step     = (cfg_step == 0) ? 1 : int'(cfg_step);
        m_n        = (cfg_interval == 0) ? 1 : int'(cfg_interval);
        m_cnt      = m_n;
        m_loop_eff = (cfg_loop && (cfg_floor < cfg_target)) ? 1 : 0;
        m_goal     = m_target;
        if (m_goal != m_duty || m_loop_eff != 0) begin
          m_active = 1;
          m_up     = (m_goal > m_duty) ? 1 : 0;
        end else begin
          m_done = 1;
        end
      end
    end else if (tk) begin
      if (m_cnt > 1) begin
        m_cnt--;
      end else begin
        m_cnt = m_n;
        nd = (m_up != 0) ? m_duty + m_step : m_duty - m_step;
        if ((m_up != 0) ? (nd >= m_goal) : (nd <= m_goal)) nd = m_goal;
        m_duty = nd;
        if (nd == m_goal) begin
          if (m_loop_eff != 0) begin
            if (m_goal == m_target) begin m_goal = m_floor;  m_up = 0; end
            else                    begin m_goal = m_target; m_up = 1; end
          end else begin
            m_active = 0;
            m_done   = 1;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      ecnt = 0;
      model_reset();
    end else begin
      ecnt++;
      model_edge(start, abort, (ecnt % FP) == 0);
    end
    #1;
    start = 1'b0;
    abort = 1'b0;
    if (rst_n && ref_tick) begin
      if (ref_first < 0) ref_first = ecnt;
      else if (ref_second < 0) ref_second = ecnt;
    end
    check("duty", int'(duty_cycle), m_duty);
    check("busy", int'(busy), m_active);
    check("done", int'(done), m_done);
    check("tick", int'(period_tick), (rst_n && (ecnt % FP == FP - 1)) ? 1 : 0);
    check("ref_tick", int'(ref_tick), (rst_n && (ecnt % RP == RP - 1)) ? 1 : 0);
  endtask

  task automatic wait_tick();
    int guard = 0;
    do begin
      step();
      guard++;
    end while ((ecnt % FP) != 0 && guard < 4 * FP);
  endtask

  initial begin
    model_reset();
    vecs[0] = mk(8'h40, 8'h00, 8'h10, 8'h01, 1'b0, 4, {8'h00, 8'h00, 8'h40, 8'h30, 8'h20, 8'h10});
    vecs[1] = mk(8'h05, 8'h00, 8'h30, 8'h01, 1'b0, 2, {8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h10});
    vecs[2] = mk(8'hF8, 8'h00, 8'h80, 8'h01, 1'b0, 2, {8'h00, 8'h00, 8'h00, 8'h00, 8'hF8, 8'h85});
    vecs[3] = mk(8'hF0, 8'h00, 8'h08, 8'h03, 1'b0, 3, {8'h00, 8'h00, 8'h00, 8'hF0, 8'hF8, 8'hF8});
    vecs[4] = mk(8'hF2, 8'h00, 8'h00, 8'h00, 1'b0, 2, {8'h00, 8'h00, 8'h00, 8'h00, 8'hF2, 8'hF1});
    vecs[5] = mk(8'h00, 8'h00, 8'hFF, 8'h01, 1'b0, 1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    vecs[6] = mk(8'h20, 8'h00, 8'h10, 8'h01, 1'b1, 6, {8'h20, 8'h10, 8'h00, 8'h10, 8'h20, 8'h10});

    repeat (3) step();
    check("reset_duty", int'(duty_cycle), 0);
    check("reset_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (4000) step();
    check("idle_duty", int'(duty_cycle), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_ref_duty", int'(ref_duty), 0);
    check("idle_ref_busy", int'(ref_busy), 0);
    check("ref_first_tick", ref_first, 3327);
    repeat (2700) step();
    check("ref_second_tick", ref_second, 6655);

    for (int i = 0; i < 7; i++) begin
      cfg_target = vecs[i].tgt; cfg_floor = vecs[i].flr; cfg_step = vecs[i].stp;
      cfg_interval = vecs[i].ivl; cfg_loop = vecs[i].lp;
      start = 1'b1;
      step();
      check($sformatf("v%0d_busy_start", i), int'(busy), 1);
      for (int t = 0; t < vecs[i].nt; t++) begin
        wait_tick();
        check($sformatf("v%0d_duty_t%0d", i, t), int'(duty_cycle), int'(vecs[i].ex[t]));
        check($sformatf("v%0d_done_t%0d", i, t), int'(done),
              (t == vecs[i].nt - 1 && !vecs[i].lp) ? 1 : 0);
      end
      if (!vecs[i].lp) begin
        step();
        check($sformatf("v%0d_busy_end", i), int'(busy), 0);
      end
    end

    abort = 1'b1;
    step();
    check("abort_busy", int'(busy), 0);
    check("abort_duty", int'(duty_cycle), 8'h20);
    check("abort_done", int'(done), 0);
    wait_tick();
    check("abort_duty_held", int'(duty_cycle), 8'h20);

    cfg_target = 8'h80; cfg_step = 8'h10; cfg_interval = 8'h01; cfg_loop = 1'b0;
    start = 1'b1; abort = 1'b1;
    step();
    check("start_abort_busy", int'(busy), 0);
    wait_tick();
    check("start_abort_duty", int'(duty_cycle), 8'h20);

    cfg_target = 8'h20;
    start = 1'b1;
    step();
    check("equal_done", int'(done), 1);
    check("equal_busy", int'(busy), 0);
    step();
    check("equal_done_clear", int'(done), 0);
    check("equal_busy_low", int'(busy), 0);

    cfg_target = 8'h60; cfg_step = 8'h10;
    start = 1'b1;
    step();
    cfg_target = 8'h00; cfg_step = 8'h01;
    start = 1'b1;
    step();
    wait_tick();
    check("restart_ignored_duty", int'(duty_cycle), 8'h30);
    check("restart_ignored_busy", int'(busy), 1);

    rst_n = 1'b0;
    step();
    step();
    check("midreset_duty", int'(duty_cycle), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_done", int'(done), 0);
    check("midreset_tick", int'(period_tick), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 4000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      cfg_target   = 8'($urandom_range(0, 255));
      cfg_floor    = 8'($urandom_range(0, 255));
      cfg_step     = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      cfg_interval = 8'($urandom_range(0, 3));
      cfg_loop     = 1'($urandom_range(0, 1));
      if (r < 4) start = 1'b1;
      else if (r < 6) abort = 1'b1;
      else if (r == 6) begin start = 1'b1; abort = 1'b1; end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
